// File: rtl/seg_step_beep_if.sv
// Step-in / display-out bundle between the time-base consumer (slave) and its driver (master).
interface seg_step_beep_if;
   logic       change_flag;
   logic       hold;
   logic [3:0] digit;
   logic [5:0] seg_sel;
   logic [7:0] seg_led;
   logic       beep;

   modport master (output change_flag, hold, input digit, seg_sel, seg_led, beep);
   modport slave  (input change_flag, hold, output digit, seg_sel, seg_led, beep);
endinterface

// File: rtl/seg_step_beep.sv
// Hex digit stepper driving a static 7-segment display; with SEG_BEEP_EN defined it also
// sounds a square-wave tone burst on the buzzer each time the digit wraps to 0.
module seg_step_beep #(
   parameter int DIGIT_MAX   = 15,
   parameter int BEEP_CYCLES = 5_000_000,
   parameter int TONE_HALF   = 12_500
) (
   input logic            clk,
   input logic            rst,
   seg_step_beep_if.slave bus
);

   if (DIGIT_MAX < 1 || DIGIT_MAX > 15 ||
       BEEP_CYCLES < 1 || BEEP_CYCLES > (1 << 23) ||
       TONE_HALF < 1 || TONE_HALF > (1 << 14)) begin : g_param_check
      $error("seg_step_beep: parameter out of range");
   end

   localparam logic [3:0] DIGIT_LAST = 4'(DIGIT_MAX);

   logic       flag_d;
   logic [3:0] digit_q;
   logic [7:0] seg_led_q;
   logic [5:0] seg_sel_q;
   logic       step;
   logic       wrap;

   // A held flag steps once; a step seen while hold is high is simply lost.
   assign step = bus.change_flag & ~flag_d & ~bus.hold;
   assign wrap = step & (digit_q == DIGIT_LAST);

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] pat;
      // NOTE: a default on every path keeps decode logic purely combinational.
      pat = 8'hFF;
      unique case (d)
         4'h0: pat = 8'hC0;
         4'h1: pat = 8'hF9;
         4'h2: pat = 8'hA4;
         4'h3: pat = 8'hB0;
         4'h4: pat = 8'h99;
         4'h5: pat = 8'h92;
         4'h6: pat = 8'h82;
         4'h7: pat = 8'hF8;
         4'h8: pat = 8'h80;
         4'h9: pat = 8'h90;
         4'hA: pat = 8'h88;
         4'hB: pat = 8'h83;
         4'hC: pat = 8'hC6;
         4'hD: pat = 8'hA1;
         4'hE: pat = 8'h86;
         4'hF: pat = 8'h8E;
         default: pat = 8'hFF;
      endcase
      return pat;
   endfunction

   // NOTE: state is updated with non-blocking assignments so every register samples
   // pre-edge values; seg_led therefore lags digit by exactly one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_d    <= 1'b0;
         digit_q   <= '0;
         seg_led_q <= 8'hFF;
         seg_sel_q <= 6'h3F;
      end else begin
         flag_d    <= bus.change_flag;
         seg_led_q <= seg_decode(digit_q);
         seg_sel_q <= 6'h00;
         if (step) begin
            digit_q <= wrap ? 4'h0 : digit_q + 4'd1;
         end
      end
   end

   assign bus.digit   = digit_q;
   assign bus.seg_led = seg_led_q;
   assign bus.seg_sel = seg_sel_q;

`ifdef SEG_BEEP_EN
   typedef enum logic {IDLE, TONE} beep_state_e;

   localparam logic [22:0] DUR_LAST  = 23'(BEEP_CYCLES - 1);
   localparam logic [13:0] TONE_LAST = 14'(TONE_HALF - 1);

   beep_state_e state;
   logic [22:0] dur_cnt;
   logic [13:0] tone_cnt;
   logic        beep_q;

   // A wrap always (re)starts the burst, whether idle or mid-tone.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         beep_q   <= 1'b0;
      end else if (wrap) begin
         state    <= TONE;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         beep_q   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               beep_q <= 1'b0;
            end
            TONE: begin
               if (dur_cnt == DUR_LAST) begin
                  state    <= IDLE;
                  dur_cnt  <= '0;
                  tone_cnt <= '0;
                  beep_q   <= 1'b0;
               end else begin
                  dur_cnt <= dur_cnt + 23'd1;
                  if (tone_cnt == TONE_LAST) begin
                     tone_cnt <= '0;
                     beep_q   <= ~beep_q;
                  end else begin
                     tone_cnt <= tone_cnt + 14'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.beep = beep_q;
`else
   assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_seg_step_beep.sv
// Self-checking bench for seg_step_beep: directed scenarios plus random stepping, all
// compared against a cycle model built from step counts and time-since-wrap arithmetic.
module tb_seg_step_beep;

   localparam int BEEP   = 20;
   localparam int TONE   = 3;
   localparam int IDLE_T = 1_000_000;
`ifdef SEG_BEEP_EN
   localparam logic BEEP_ON = 1'b1;
`else
   localparam logic BEEP_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   seg_step_beep_if bus0 ();
   seg_step_beep_if bus1 ();

   seg_step_beep #(.DIGIT_MAX(15), .BEEP_CYCLES(BEEP), .TONE_HALF(TONE)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   seg_step_beep #(.DIGIT_MAX(1), .BEEP_CYCLES(BEEP), .TONE_HALF(TONE)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model: digit is the step count modulo (DIGIT_MAX+1); the tone is a pure
   // function of how many cycles have elapsed since the most recent wrap.
   int         m_max   [2] = '{15, 1};
   int         m_steps [2];
   int         m_digit [2];
   int         m_since [2];
   logic       m_flag_d[2];
   logic [7:0] m_seg   [2];
   logic [5:0] m_sel   [2];

   always @(posedge clk) begin : model
      logic f, h;
      for (int i = 0; i < 2; i++) begin
         f = (i == 0) ? bus0.change_flag : bus1.change_flag;
         h = (i == 0) ? bus0.hold : bus1.hold;
         if (rst) begin
            m_steps[i]  = 0;
            m_digit[i]  = 0;
            m_since[i]  = IDLE_T;
            m_flag_d[i] = 1'b0;
            m_seg[i]    = 8'hFF;
            m_sel[i]    = 6'h3F;
         end else begin
            m_seg[i] = seg_tab[m_digit[i]];
            m_sel[i] = 6'h00;
            if (f && !m_flag_d[i] && !h) begin
               m_steps[i] = m_steps[i] + 1;
               m_digit[i] = m_steps[i] % (m_max[i] + 1);
               if (m_digit[i] == 0) m_since[i] = -1;
            end
            if (m_since[i] < IDLE_T) m_since[i] = m_since[i] + 1;
            m_flag_d[i] = f;
         end
      end
   end

   function automatic logic [18:0] exp_vec(input int i);
      logic b;
`ifdef SEG_BEEP_EN
      b = (m_since[i] < BEEP) && ((m_since[i] / TONE) % 2 == 0);
`else
      b = 1'b0;
`endif
      return {4'(m_digit[i]), m_seg[i], m_sel[i], b};
   endfunction

   logic [18:0] obs0, obs1;
   assign obs0 = {bus0.digit, bus0.seg_led, bus0.seg_sel, bus0.beep};
   assign obs1 = {bus1.digit, bus1.seg_led, bus1.seg_sel, bus1.beep};

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (obs0 !== {4'h0, 8'hFF, 6'h3F, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs0, {4'h0, 8'hFF, 6'h3F, 1'b0});
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs0 !== {4'h0, 8'hC0, 6'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_release0: got %h want %h", obs0, {4'h0, 8'hC0, 6'h00, 1'b0});
      end
      checks++;
      if (obs1 !== {4'h0, 8'hC0, 6'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_release1: got %h want %h", obs1, {4'h0, 8'hC0, 6'h00, 1'b0});
      end
   endtask

   task automatic test_step_wrap();
      for (int p = 1; p <= 16; p++) begin
         bus0.change_flag = 1'b1;
         @(negedge clk);
         bus0.change_flag = 1'b0;
         checks++;
         if (bus0.digit !== 4'(p % 16) || bus0.seg_led !== seg_tab[(p - 1) % 16]) begin
            errors++;
            $display("FAIL step_edge p=%0d: digit %h seg %h want %h %h", p, bus0.digit,
                     bus0.seg_led, 4'(p % 16), seg_tab[(p - 1) % 16]);
         end
         if (p == 16) begin
            checks++;
            if (bus0.beep !== BEEP_ON) begin
               errors++;
               $display("FAIL wrap_beep_rise: got %b want %b", bus0.beep, BEEP_ON);
            end
         end
         for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (obs0 !== exp_vec(0)) begin
               errors++;
               $display("FAIL step_track p=%0d c=%0d: got %h want %h", p, c, obs0, exp_vec(0));
            end
            if (c == 1) begin
               checks++;
               if (bus0.seg_led !== seg_tab[p % 16]) begin
                  errors++;
                  $display("FAIL seg_lag p=%0d: got %h want %h", p, bus0.seg_led, seg_tab[p % 16]);
               end
            end
            if (p == 16 && (c == 19 || c == 20)) begin
               checks++;
               if (bus0.beep !== ((c == 19) ? BEEP_ON : 1'b0)) begin
                  errors++;
                  $display("FAIL burst_end c=%0d: got %b want %b", c, bus0.beep,
                           (c == 19) ? BEEP_ON : 1'b0);
               end
            end
         end
      end
   endtask

   task automatic test_held_flag();
      logic [3:0] start;
      start = bus0.digit;
      bus0.change_flag = 1'b1;
      repeat (5) @(negedge clk);
      bus0.change_flag = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus0.digit !== start + 4'd1) begin
         errors++;
         $display("FAIL held_flag: got %h want %h", bus0.digit, start + 4'd1);
      end
      start = start + 4'd1;
      bus0.hold = 1'b1;
      bus0.change_flag = 1'b1;
      @(negedge clk);
      bus0.change_flag = 1'b0;
      @(negedge clk);
      bus0.hold = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus0.digit !== start) begin
         errors++;
         $display("FAIL hold_pulse: got %h want %h", bus0.digit, start);
      end
      bus0.hold = 1'b1;
      bus0.change_flag = 1'b1;
      @(negedge clk);
      bus0.hold = 1'b0;
      repeat (3) @(negedge clk);
      bus0.change_flag = 1'b0;
      @(negedge clk);
      checks++;
      if (obs0 !== exp_vec(0) || bus0.digit !== start) begin
         errors++;
         $display("FAIL hold_release: got %h want digit %h", obs0, start);
      end
   endtask

   task automatic test_retrigger();
      for (int t = 0; t <= 50; t++) begin
         bus1.change_flag = (t % 8 == 0) && (t <= 24);
         @(negedge clk);
         checks++;
         if (obs1 !== exp_vec(1)) begin
            errors++;
            $display("FAIL retrig_track t=%0d: got %h want %h", t, obs1, exp_vec(1));
         end
         if (t == 24 || t == 43 || t == 44) begin
            checks++;
            if (bus1.beep !== ((t == 44) ? 1'b0 : BEEP_ON)) begin
               errors++;
               $display("FAIL retrig_beep t=%0d: got %b want %b", t, bus1.beep,
                        (t == 44) ? 1'b0 : BEEP_ON);
            end
         end
      end
      bus1.change_flag = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      for (int n = 0; n < 20 && bus0.digit != 4'hF; n++) begin
         bus0.change_flag = 1'b1;
         @(negedge clk);
         bus0.change_flag = 1'b0;
         @(negedge clk);
      end
      bus0.change_flag = 1'b1;
      @(negedge clk);
      bus0.change_flag = 1'b0;
      checks++;
      if (bus0.digit !== 4'h0 || bus0.beep !== BEEP_ON) begin
         errors++;
         $display("FAIL midburst_wrap: digit %h beep %b want 0 %b", bus0.digit, bus0.beep, BEEP_ON);
      end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs0 !== {4'h0, 8'hFF, 6'h3F, 1'b0}) begin
         errors++;
         $display("FAIL midburst_rst: got %h want %h", obs0, {4'h0, 8'hFF, 6'h3F, 1'b0});
      end
      rst = 1'b0;
      bus0.change_flag = 1'b1;
      @(negedge clk);
      bus0.change_flag = 1'b0;
      checks++;
      if (obs0 !== {4'h1, 8'hC0, 6'h00, 1'b0}) begin
         errors++;
         $display("FAIL first_cycle_step: got %h want %h", obs0, {4'h1, 8'hC0, 6'h00, 1'b0});
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         checks++;
         if (bus0.beep !== 1'b0 || obs0 !== exp_vec(0)) begin
            errors++;
            $display("FAIL post_rst_quiet c=%0d: got %h want %h", c, obs0, exp_vec(0));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus0.change_flag = ($urandom_range(0, 2) == 0);
         bus0.hold        = ($urandom_range(0, 3) == 0);
         bus1.change_flag = ($urandom_range(0, 2) == 0);
         bus1.hold        = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         checks++;
         if (obs0 !== exp_vec(0)) begin
            errors++;
            $display("FAIL random0 c=%0d: got %h want %h", c, obs0, exp_vec(0));
         end
         checks++;
         if (obs1 !== exp_vec(1)) begin
            errors++;
            $display("FAIL random1 c=%0d: got %h want %h", c, obs1, exp_vec(1));
         end
      end
      bus0.change_flag = 1'b0;
      bus0.hold        = 1'b0;
      bus1.change_flag = 1'b0;
      bus1.hold        = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus0.change_flag = 1'b0;
      bus0.hold        = 1'b0;
      bus1.change_flag = 1'b0;
      bus1.hold        = 1'b0;
      test_reset();
      test_step_wrap();
      test_held_flag();
      test_retrigger();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
